tx_scheduler: RTL and testbench
===============================

// Module: tx_scheduler
// PURPOSE
//  Shares the single pulse-width IR/audio transmitter between N_REQ requesters.
//  Round-robin arbiter: captures one word from a requester and prefixes it with the requester ID.
//  Issues the tagged word to the transmitter as a one-cycle valid, then tracks the
//  transmitter busy flag until the frame completes.
//  Inserts a programmable inter-frame gap; flags a transmitter that never accepts.
// PARAMETERS
//  N_REQ   4    number of requesters (>=2)
//  DATA_W  6    payload bits per requester word
//  ID_W    2    requester tag bits; must satisfy 2**ID_W >= N_REQ
//  GAP     1000 idle cycles enforced after tx busy falls (0 = no gap)
//  ACK_TO  16   max cycles to wait for tx busy to rise after issue
// PORTS
//  clk_in         in   1                 system clock (98.3 MHz)
//  rst_in         in   1                 reset, synchronous, active-low
//  req_valid_in   in   N_REQ             per-requester word available
//  req_data_in    in   N_REQ*DATA_W      packed payloads; requester k at [k*DATA_W +: DATA_W]
//  req_ready_out  out  N_REQ             one-hot, one-cycle accept strobe
//  tx_busy_in     in   1                 transmitter busy flag
//  tx_valid_out   out  1                 one-cycle start strobe to transmitter
//  tx_signal_out  out  ID_W+DATA_W       {id, payload}; MSB first on air
//  active_out     out  1                 high in any state other than IDLE
//  timeout_out    out  1                 one-cycle pulse on ACK_TO expiry
// BEHAVIOUR
//  Reset (rst_in==0 at posedge): state=IDLE, counters=0, last_grant=N_REQ-1,
//   tx_valid_out=0, tx_signal_out=0, timeout_out=0.
//   Reset overrides everything, including mid-frame. req_ready_out=0 during reset.
//  Requester rule: hold valid and data stable until ready is seen. Ready is never asserted without valid.
//  States:
//   IDLE: search order last_grant+1, +2, ... (mod N_REQ). The first k with valid wins.
//    req_ready_out[k]=1 combinationally in this cycle.
//    Register tx_signal_out={k[ID_W-1:0], data_k}. Set last_grant=k. Go to ISSUE.
//    If no valid, stay in IDLE.
//   ISSUE: tx_valid_out=1 for exactly this cycle, counter=0, go to WAIT_ACK.
//   WAIT_ACK: if tx_busy_in, go to SENDING.
//    Else if counter==ACK_TO-1: pulse timeout_out, go to GAP (word dropped).
//    Else counter++.
//   SENDING: when tx_busy_in==0, load counter=0 and go to GAP, or go to IDLE if GAP==0.
//   GAP: counter++; when counter==GAP-1, go to IDLE.
//  Latency: accept at cycle t, tx_valid_out at t+1, earliest next accept at
//   (busy fall)+GAP+1.
//  Round-robin fairness: with all valids held high, grants go 0,1,...,N_REQ-1,0,...
//   A requester waits at most N_REQ-1 frames.
//  Valids arriving during non-IDLE states are held off. No buffering beyond one word.
//  tx_busy_in high while in IDLE (foreign use) blocks arbitration: IDLE grants
//   only when tx_busy_in==0.
//  tx_signal_out holds its value until the next grant.
//  Counters are 16-bit; GAP and ACK_TO must each be < 65536.
// TESTING
//  1 Reset: hold rst_in=0 for 5 cycles with all valids=1 -> no ready, tx_valid_out=0, active_out=0.
//  2 Single request: req 2 valid, data 6'h2A -> ready[2] pulses once;
//    next cycle tx_valid_out=1 with tx_signal_out=8'hAA; GAP idle cycles occur after busy falls.
//  3 Round-robin: all 4 valids held -> grant order 0,1,2,3,0.
//    IDs in tx_signal_out[7:6] match the grant order.
//  4 Timeout: tx_busy_in tied 0, req 1 valid -> timeout_out pulses 16 cycles after issue;
//    next grant only after GAP.
//  5 Mid-frame reset: assert rst_in=0 while SENDING -> all outputs at reset values next cycle;
//    after release, a pending req 0 is granted first.
//  6 Foreign busy: tx_busy_in=1 in IDLE with req 3 valid -> no grant until busy falls,
//    then ready[3] on the first cycle with busy low.

Source files
------------

// File: rtl/tx_scheduler.sv
// Round-robin scheduler sharing one pulse-width transmitter between N_REQ requesters.
// Tags each accepted word with its requester ID, then tracks tx busy, ack timeout and inter-frame gap.
module tx_scheduler #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 6,
  parameter int ID_W   = 2,
  parameter int GAP    = 1000,
  parameter int ACK_TO = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [N_REQ-1:0]         req_valid_in,
  input  logic [N_REQ*DATA_W-1:0]  req_data_in,
  output logic [N_REQ-1:0]         req_ready_out,
  input  logic                     tx_busy_in,
  output logic                     tx_valid_out,
  output logic [ID_W+DATA_W-1:0]   tx_signal_out,
  output logic                     active_out,
  output logic                     timeout_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_SENDING,
    S_GAP
  } state_t;

  localparam logic [15:0] ACK_LAST = 16'(ACK_TO - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP - 1);

  state_t                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [ID_W-1:0]         last_q, last_d;
  logic [ID_W+DATA_W-1:0]  sig_q, sig_d;

  logic                    found;
  logic [ID_W-1:0]         pick;
  int                      idx;

  // Rotating priority: the requester after the last grant is checked first.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last_q) + i) % N_REQ;
      if (!found && req_valid_in[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    sig_d         = sig_q;
    req_ready_out = '0;
    timeout_out   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A busy transmitter in IDLE belongs to someone else; hold off arbitration.
        if (rst_in && found && !tx_busy_in) begin
          req_ready_out[pick] = 1'b1;
          sig_d   = {pick, req_data_in[int'(pick)*DATA_W +: DATA_W]};
          last_d  = pick;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (tx_busy_in) begin
          state_d = S_SENDING;
        end else if (cnt_q == ACK_LAST) begin
          timeout_out = rst_in;
          cnt_d       = '0;
          state_d     = (GAP == 0) ? S_IDLE : S_GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SENDING: begin
        if (!tx_busy_in) begin
          cnt_d   = '0;
          state_d = (GAP == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_IDLE;
        else                   cnt_d   = cnt_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sig_q   <= sig_d;
    end
  end

  assign tx_valid_out  = (state_q == S_ISSUE);
  assign active_out    = (state_q != S_IDLE);
  assign tx_signal_out = sig_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed plus randomized frames against a cycle-count model of the scheduler's rules.
module tb_tx_scheduler;
  localparam int N  = 4;
  localparam int DW = 6;
  localparam int IW = 2;
  localparam int G  = 10;
  localparam int AT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      reqv;
  logic [N*DW-1:0]   reqd;
  logic [N-1:0]      rdy;
  logic              busy;
  logic              txv;
  logic [IW+DW-1:0]  sig;
  logic              act;
  logic              tmo;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0]  pend;
  logic [DW-1:0] dat [N];
  logic [N-1:0]  zero = '0;
  int            mlast;
  int            gw, gid;

  always #5 clk = ~clk;

  tx_scheduler #(.N_REQ(N), .DATA_W(DW), .ID_W(IW), .GAP(G), .ACK_TO(AT)) dut (
    .clk_in(clk), .rst_in(rst), .req_valid_in(reqv), .req_data_in(reqd),
    .req_ready_out(rdy), .tx_busy_in(busy), .tx_valid_out(txv),
    .tx_signal_out(sig), .active_out(act), .timeout_out(tmo)
  );

  task automatic fl(input string tag, input logic [31:0] o, input logic [31:0] e);
    failures++;
    $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
  endtask

  function automatic int rr_pick(logic [N-1:0] v, int last);
    for (int i = 1; i <= N; i++)
      if (v[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    reqv = pend;
    for (int k = 0; k < N; k++) reqd[k*DW +: DW] = dat[k];
  endtask

  task automatic add_reqs(input logic [N-1:0] m);
    for (int k = 0; k < N; k++)
      if (m[k] && !pend[k]) begin
        pend[k] = 1'b1;
        dat[k]  = DW'($urandom);
      end
  endtask

  // Starts in an IDLE cycle; ends at the first cycle the scheduler should be IDLE again.
  task automatic frame(input int ack_dly, input int blen, input logic [N-1:0] refill,
                       output int ow, output int oid);
    int w;
    logic [N-1:0] oh;
    logic [IW+DW-1:0] es;
    ow = -1; oid = -1;
    busy = 1'b0;
    drive();
    #1;
    w  = rr_pick(pend, mlast);
    oh = '0;
    if (w >= 0) oh[w] = 1'b1;
    checks++; if (rdy !== oh) fl("grant", rdy, oh);
    checks++; if (act !== 1'b0) fl("idle_active", act, 1'b0);
    for (int k = 0; k < N; k++) if (rdy[k]) ow = k;
    if (w < 0) begin
      step();
      return;
    end
    es = {IW'(w), dat[w]};
    mlast = w;
    pend[w] = 1'b0;
    add_reqs(refill);
    step();
    drive();
    #1;
    checks++; if (txv !== 1'b1) fl("issue_valid", txv, 1'b1);
    checks++; if (sig !== es) fl("issue_sig", sig, es);
    checks++; if (rdy !== zero) fl("ready_once", rdy, zero);
    oid = int'(sig[IW+DW-1:DW]);
    if (ack_dly >= AT) begin
      for (int i = 1; i <= AT; i++) begin
        step();
        #1;
        checks++; if (tmo !== (i == AT)) fl("to_pulse", tmo, (i == AT));
        checks++; if (rdy !== zero) fl("wait_ready", rdy, zero);
        checks++; if (txv !== 1'b0) fl("wait_valid", txv, 1'b0);
      end
    end else begin
      for (int i = 1; i <= ack_dly; i++) begin
        step();
        #1;
        checks++; if (tmo !== 1'b0) fl("no_to_ack", tmo, 1'b0);
      end
      for (int i = 1; i <= blen; i++) begin
        step();
        busy = 1'b1;
        #1;
        checks++; if (rdy !== zero) fl("send_hold", rdy, zero);
        checks++; if (tmo !== 1'b0) fl("no_to_send", tmo, 1'b0);
      end
      step();
      busy = 1'b0;
      #1;
      checks++; if (act !== 1'b1) fl("fall_active", act, 1'b1);
      checks++; if (rdy !== zero) fl("fall_ready", rdy, zero);
    end
    for (int i = 1; i <= G; i++) begin
      step();
      #1;
      checks++; if (rdy !== zero) fl("gap_hold", rdy, zero);
      checks++; if (act !== 1'b1) fl("gap_active", act, 1'b1);
      checks++; if (tmo !== 1'b0) fl("gap_no_to", tmo, 1'b0);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; reqv = '1; reqd = '0; busy = 1'b0; pend = '0;
    for (int k = 0; k < N; k++) dat[k] = '0;

    // Reset held with every requester asserting valid.
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      checks++; if (rdy !== zero) fl("rst_ready", rdy, zero);
      checks++; if (txv !== 1'b0) fl("rst_txv", txv, 1'b0);
      checks++; if (act !== 1'b0) fl("rst_active", act, 1'b0);
    end
    checks++; if (sig !== 8'h00) fl("rst_sig", sig, 8'h00);
    checks++; if (tmo !== 1'b0) fl("rst_to", tmo, 1'b0);
    rst = 1'b1; reqv = '0; mlast = N - 1;
    step();

    // Single request from requester 2.
    pend = 4'b0100; dat[2] = 6'h2A;
    frame(2, 3, 4'b0000, gw, gid);
    checks++; if (gw != 2) fl("single_grant", gw, 2);
    checks++; if (gid != 2) fl("single_id", gid, 2);

    // Round-robin with every valid held after a fresh reset.
    rst = 1'b0;
    step();
    rst = 1'b1; mlast = N - 1;
    for (int i = 0; i < 5; i++) begin
      add_reqs(4'hF);
      frame(1, 2, 4'b0000, gw, gid);
      checks++; if (gw != i % N) fl("rr_grant", gw, i % N);
      checks++; if (gid != i % N) fl("rr_id", gid, i % N);
    end

    // Ack timeout; requester 1 re-requests at once and must wait out the gap.
    pend = '0;
    add_reqs(4'b0010);
    frame(99, 0, 4'b0010, gw, gid);
    checks++; if (gw != 1) fl("to_grant", gw, 1);
    frame(AT - 1, 1, 4'b0000, gw, gid);
    checks++; if (gw != 1) fl("after_to_grant", gw, 1);

    // Reset while SENDING; requester 0 must then win over requester 3.
    pend = '0;
    add_reqs(4'b0100);
    busy = 1'b0;
    drive();
    #1;
    checks++; if (rdy !== 4'b0100) fl("t5_grant", rdy, 4'b0100);
    pend = '0; mlast = 2;
    step();
    step();
    busy = 1'b1;
    step();
    #1;
    checks++; if (act !== 1'b1) fl("t5_sending", act, 1'b1);
    add_reqs(4'b1001);
    drive();
    rst = 1'b0;
    #1;
    checks++; if (rdy !== zero) fl("t5_rst_ready", rdy, zero);
    step();
    #1;
    checks++; if (txv !== 1'b0) fl("t5_txv", txv, 1'b0);
    checks++; if (act !== 1'b0) fl("t5_active", act, 1'b0);
    checks++; if (tmo !== 1'b0) fl("t5_to", tmo, 1'b0);
    checks++; if (sig !== 8'h00) fl("t5_sig", sig, 8'h00);
    rst = 1'b1; busy = 1'b0; mlast = N - 1;
    frame(3, 2, 4'b0000, gw, gid);
    checks++; if (gw != 0) fl("t5_first", gw, 0);

    // Foreign busy in IDLE blocks requester 3 until it falls.
    pend = '0;
    add_reqs(4'b1000);
    for (int i = 0; i < 4; i++) begin
      busy = 1'b1;
      drive();
      #1;
      checks++; if (rdy !== zero) fl("fb_ready", rdy, zero);
      checks++; if (act !== 1'b0) fl("fb_active", act, 1'b0);
      step();
    end
    frame(0, 2, 4'b0000, gw, gid);
    checks++; if (gw != 3) fl("fb_grant", gw, 3);

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      if (pend == '0) add_reqs(4'($urandom_range(1, 15)));
      frame(int'($urandom_range(0, AT + 3)), int'($urandom_range(1, 6)),
            4'($urandom), gw, gid);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
